piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out companion to the SIPO block.
- Accepts one frame of MEMORY_WID words of DATA_WID bits in a single load handshake.
- Emits the frame one word per accepted output beat over a valid/ready stream.
- Reconstructs, word by word, the stream the SIPO collects; used on the transmit side of the same datapath.

Parameters:
- DATA_WID, 8, width of one word.
- MEMORY_WID, 4, words per frame; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  Data_in holds a frame to load.
- load_ready  output  1  block can accept a frame this cycle.
- Data_in  input  DATA_WID*MEMORY_WID  frame. Word k sits at bits [k*DATA_WID +: DATA_WID]. Word 0 is sent first.
- out_valid  output  1  Data_out holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- Data_out  output  DATA_WID  current serial word.
- out_last  output  1  high with the final word (index MEMORY_WID-1) of a frame.
- busy  output  1  high while a frame is held (state SHIFT).

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, index=0, frame register=0.
  - out_valid=0, out_last=0, busy=0, Data_out=0.
  - load_ready=1 from the first cycle after reset deasserts.
- A reset asserted mid-frame discards the remaining words; no partial-frame completion.
- State IDLE:
  - load_ready=1, out_valid=0, Data_out=0.
  - A load handshake (load_valid & load_ready) at edge N captures Data_in, sets index=0 and moves to SHIFT.
  - From cycle N+1: out_valid=1, Data_out=word 0. Latency is 1 cycle from load to first word.
- State SHIFT:
  - out_valid=1, busy=1, Data_out=word[index].
  - out_last=1 iff index==MEMORY_WID-1.
- Output beat (out_valid & out_ready at an edge):
  - if index < MEMORY_WID-1: index increments.
  - if index == MEMORY_WID-1: the frame ends.
- While out_valid=1 and out_ready=0, Data_out, out_last and index hold stable. No word is skipped or duplicated.
- load_ready in SHIFT is combinational: load_ready = (index==MEMORY_WID-1) & out_ready. This lets a new frame load in the same cycle the last word is accepted.
- Frame end:
  - With a simultaneous load handshake: capture the new frame, index=0, stay in SHIFT. The next cycle shows word 0 of the new frame, with no bubble.
  - Without one: return to IDLE, out_valid=0 next cycle.
- load_valid while load_ready=0 is ignored. The upstream must hold Data_in and load_valid until the handshake.
- Index counter width is $clog2(MEMORY_WID). Index never exceeds MEMORY_WID-1; there is no wrap past the frame.
- Steady state with out_ready=1 and back-to-back loads is 1 word per cycle, 100% throughput.

Test Plan:
- Reset: drive rst=1 for 3 cycles with load_valid=1 -> out_valid=0, Data_out=0x00, busy=0 throughout. load_ready=1 on the first cycle after rst=0.
- Single frame, out_ready=1: load Data_in=0x44332211 -> on the 4 cycles after the load, Data_out=0x11,0x22,0x33,0x44. out_last=1 only with 0x44. out_valid=0 on the following cycle.
- Backpressure: load 0xDDCCBBAA, out_ready toggling 1,0,0,1,1,0,1 -> accepted sequence is exactly AA,BB,CC,DD. Data_out is stable on every out_ready=0 cycle.
- Back-to-back: two frames 0x04030201 then 0x08070605 with load_valid held, out_ready=1 -> 8 consecutive valid words 01..08 with no gap. out_last on 04 and 08. The second load handshake coincides with 04 being accepted.
- Load ignored while busy: assert load_valid with 0xFFFFFFFF during word 1 of frame 0x44332211 -> the output remains 11,22,33,44. 0xFF words appear only after the handshake on the last beat.
- Reset mid-frame: assert rst after 0x22 is accepted -> next cycle out_valid=0, busy=0. A following load of 0x0D0C0B0A yields 0A,0B,0C,0D with no residual 0x33/0x44.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads one frame of MEMORY_WID words in a
// single handshake and streams it word 0 first over a valid/ready interface.
module piso_serializer #(
    parameter int unsigned DATA_WID   = 8,
    parameter int unsigned MEMORY_WID = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [DATA_WID*MEMORY_WID-1:0] Data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WID-1:0]            Data_out,
    output logic                           out_last,
    output logic                           busy
);

    localparam int unsigned FRAME_W  = DATA_WID * MEMORY_WID;
    localparam int unsigned IDX_W    = $clog2(MEMORY_WID);
    localparam int unsigned LAST_IDX = MEMORY_WID - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   index_q;
    logic [FRAME_W-1:0] frame_q;

    logic at_last;
    logic beat;
    logic load_hs;

    // Handshake decode; a new frame may load on the cycle the final word leaves.
    always_comb begin
        at_last    = (index_q == IDX_W'(LAST_IDX));
        beat       = (state_q == SHIFT) && out_ready;
        load_ready = (state_q == IDLE) || (at_last && out_ready);
        load_hs    = load_valid && load_ready;
    end

    // Frame register shifts down one word per beat, so word[index] is always in
    // the low slice and the register drains to zero as the frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            frame_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_hs) begin
                        frame_q <= Data_in;
                        index_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        if (at_last) begin
                            index_q <= '0;
                            if (load_hs) begin
                                frame_q <= Data_in;
                            end else begin
                                frame_q <= '0;
                                state_q <= IDLE;
                            end
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                            frame_q <= frame_q >> DATA_WID;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    index_q <= '0;
                    frame_q <= '0;
                end
            endcase
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign out_last  = (state_q == SHIFT) && at_last;
    assign Data_out  = frame_q[DATA_WID-1:0];

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: loads push their words into an expected
// queue; a negedge monitor compares every presented word and status output.
module tb_piso_serializer;

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DW*MW-1:0]  Data_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     Data_out;
    logic              out_last;
    logic              busy;

    piso_serializer #(.DATA_WID(DW), .MEMORY_WID(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .Data_in    (Data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Data_out   (Data_out),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] word;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   armed = 1'b0;

    bit   ready_pat[$];
    int   ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: compare current outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_lr;
        exp_valid = (exp_q.size() != 0);
        exp_lr    = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        if (armed) begin
            check("out_valid",  32'(out_valid),  32'(exp_valid));
            check("busy",       32'(busy),       32'(exp_valid));
            check("load_ready", 32'(load_ready), 32'(exp_lr));
            check("data_out",   32'(Data_out),   exp_valid ? 32'(exp_q[0].word) : 32'd0);
            check("out_last",   32'(out_last),   exp_valid ? 32'(exp_q[0].last) : 32'd0);
        end
        if (rst) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (exp_valid && out_ready) void'(exp_q.pop_front());
            if (load_valid && exp_lr) begin
                for (int k = 0; k < int'(MW); k++) begin
                    exp_t e;
                    e.word = Data_in[k*DW +: DW];
                    e.last = (k == int'(MW) - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Downstream ready: explicit pattern first, then always-ready or random.
    always @(posedge clk) begin
        #1;
        if (ready_pat.size() != 0) out_ready = ready_pat.pop_front();
        else if (ready_mode != 0)  out_ready = 1'($urandom_range(0, 1));
        else                       out_ready = 1'b1;
    end

    // Present a frame and hold it until the block accepts it; load_valid stays high.
    task automatic send_frame(input logic [DW*MW-1:0] d);
        bit done;
        bit hs;
        done = 1'b0;
        load_valid = 1'b1;
        Data_in    = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            hs = load_ready;
            @(posedge clk);
            #1;
            if (hs) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: frame 0x%0h not accepted", d);
        end
    endtask

    task automatic idle_load();
        load_valid = 1'b0;
        Data_in    = '0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            cycles(1);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding", exp_q.size());
        end
        cycles(2);
    endtask

    initial begin
        // Reset with load_valid asserted; it must not take effect.
        rst        = 1'b1;
        load_valid = 1'b1;
        Data_in    = 32'hFFFF_FFFF;
        cycles(3);
        rst = 1'b0;
        idle_load();
        cycles(2);

        // Single frame, downstream always ready.
        send_frame(32'h4433_2211);
        idle_load();
        wait_drain();

        // Backpressure pattern.
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        send_frame(32'hDDCC_BBAA);
        idle_load();
        wait_drain();

        // Back-to-back frames with load_valid held.
        send_frame(32'h0403_0201);
        send_frame(32'h0807_0605);
        idle_load();
        wait_drain();

        // Load attempted mid-frame must wait for the final beat.
        send_frame(32'h4433_2211);
        idle_load();
        cycles(1);
        send_frame(32'hFFFF_FFFF);
        idle_load();
        wait_drain();

        // Reset after the second word is accepted.
        send_frame(32'h4433_2211);
        idle_load();
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        send_frame(32'h0D0C_0B0A);
        idle_load();
        wait_drain();

        // Random frames, random gaps and random backpressure.
        ready_mode = 1;
        for (int f = 0; f < 30; f++) begin
            send_frame($urandom);
            if ($urandom_range(0, 2) != 0) begin
                idle_load();
                cycles(int'($urandom_range(0, 3)));
            end
        end
        idle_load();
        ready_mode = 0;
        wait_drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
